// File: rtl/mux_stream_n.sv
// -----------------------------------------------------------------------------
// mux_stream_n
// N-channel streaming multiplexer with a single registered output stage.
// A channel is chosen either by sel_in (fixed mode) or round-robin across the
// channels that currently present a beat. The chosen beat is captured into an
// output register that is drained by a downstream valid/ready handshake.
//
// Handshake rule (all ports): a beat moves on a rising clk_in edge when valid
// and ready are both 1 in that cycle. The producer holds data/last stable
// while valid=1 and ready=0. Ready never waits for valid on the same channel,
// except through the grant choice.
//
// Optional feature: define MUX_STREAM_LOCK_EN to enable packet lock. Once a
// channel starts a packet (beat with last=0), it keeps the grant until its
// last beat is accepted. Without the macro, grants are per beat.
//
// Parameters:
//   NUM_CH  number of input channels (>= 2, any value)
//   DATA_W  data width per channel (>= 1)
//   SEL_W   derived select width, do not override
//
// Ports:
//   clk_in       clock, rising edge
//   rst_in       synchronous active-high reset
//   data_in      channel k data at [k*DATA_W +: DATA_W]
//   valid_in     per-channel beat present
//   last_in      per-channel last-of-packet flag
//   ready_out    per-channel accept (one-hot or zero)
//   mode_in      0 = fixed select, 1 = round-robin
//   sel_in       channel used in fixed mode
//   y_data_out   registered output data
//   y_last_out   registered last flag
//   y_ch_out     source channel of the registered beat
//   y_valid_out  output beat valid
//   y_ready_in   downstream ready
// -----------------------------------------------------------------------------
module mux_stream_n #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 8,
   parameter int SEL_W  = $clog2(NUM_CH)
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic [NUM_CH*DATA_W-1:0] data_in,
   input  logic [NUM_CH-1:0]        valid_in,
   input  logic [NUM_CH-1:0]        last_in,
   output logic [NUM_CH-1:0]        ready_out,
   input  logic                     mode_in,
   input  logic [SEL_W-1:0]         sel_in,
   output logic [DATA_W-1:0]        y_data_out,
   output logic                     y_last_out,
   output logic [SEL_W-1:0]         y_ch_out,
   output logic                     y_valid_out,
   input  logic                     y_ready_in
);

   localparam logic [SEL_W:0]   NUM_CH_W = (SEL_W+1)'(NUM_CH);
   localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH-1);

   // Control state, kept in one struct so checkers can bind to it directly.
`ifdef MUX_STREAM_LOCK_EN
   typedef struct packed {
      logic             lock;
      logic [SEL_W-1:0] lock_ch;
      logic [SEL_W-1:0] rr_ptr;
   } state_t;
`else
   typedef struct packed {
      logic [SEL_W-1:0] rr_ptr;
   } state_t;
`endif

   state_t state_q;
   state_t state_d;

   logic              grant_vld;
   logic [SEL_W-1:0]  grant_ch;
   logic [SEL_W:0]    rr_sum;
   logic              load_ok;
   logic              accept;
   logic [DATA_W-1:0] sel_data;
   logic              sel_last;

   // Output register may take a new beat when empty or being drained now.
   assign load_ok = !y_valid_out || y_ready_in;
   assign accept  = grant_vld && load_ok && !rst_in;

   // ---------------------------------------------------------------------------
   // Grant selection (combinational)
   // ---------------------------------------------------------------------------
   always_comb begin
      grant_vld = 1'b0;
      grant_ch  = '0;
      rr_sum    = '0;
`ifdef MUX_STREAM_LOCK_EN
      if (state_q.lock) begin
         grant_vld = valid_in[state_q.lock_ch];
         grant_ch  = state_q.lock_ch;
      end else
`endif
      if (mode_in) begin
         // Walk from farthest to nearest offset so the channel closest to
         // rr_ptr is the one left standing.
         for (int i = NUM_CH-1; i >= 0; i--) begin
            rr_sum = {1'b0, state_q.rr_ptr} + (SEL_W+1)'(i);
            if (rr_sum >= NUM_CH_W) begin
               rr_sum = rr_sum - NUM_CH_W;
            end
            if (valid_in[rr_sum[SEL_W-1:0]]) begin
               grant_vld = 1'b1;
               grant_ch  = rr_sum[SEL_W-1:0];
            end
         end
      end else if ({1'b0, sel_in} < NUM_CH_W) begin
         // Out-of-range selects (only possible when NUM_CH is not a power
         // of two) grant nothing.
         grant_vld = valid_in[sel_in];
         grant_ch  = sel_in;
      end
   end

   // Data/last of the granted channel.
   always_comb begin
      sel_data = '0;
      sel_last = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (grant_ch == SEL_W'(k)) begin
            sel_data = data_in[k*DATA_W +: DATA_W];
            sel_last = last_in[k];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Control state: register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= '0;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Control state: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      if (accept) begin
         // Pointer moves past the served channel in both modes.
         state_d.rr_ptr = (grant_ch == LAST_CH) ? '0 : grant_ch + 1'b1;
`ifdef MUX_STREAM_LOCK_EN
         if (state_q.lock) begin
            // While locked the grant is always lock_ch.
            if (sel_last) begin
               state_d.lock = 1'b0;
            end
         end else if (!sel_last) begin
            // First beat of a multi-beat packet; single-beat packets never lock.
            state_d.lock    = 1'b1;
            state_d.lock_ch = grant_ch;
         end
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Control state: outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      ready_out = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         ready_out[k] = accept && (grant_ch == SEL_W'(k));
      end
   end

   // ---------------------------------------------------------------------------
   // Output register stage
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         y_valid_out <= 1'b0;
         y_data_out  <= '0;
         y_last_out  <= 1'b0;
         y_ch_out    <= '0;
      end else if (accept) begin
         // Also covers drain-and-refill in the same cycle, with no bubble.
         y_valid_out <= 1'b1;
         y_data_out  <= sel_data;
         y_last_out  <= sel_last;
         y_ch_out    <= grant_ch;
      end else if (y_ready_in) begin
         // Drained with nothing new: payload keeps its old value.
         y_valid_out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_stream_n.sv
// -----------------------------------------------------------------------------
// tb_mux_stream_n
// Directed-vector bench for mux_stream_n (NUM_CH=4, DATA_W=8). Expected beats
// are hand-computed and queued; outputs are sampled 1-2 time units after the
// rising edge. Follows MUX_STREAM_LOCK_EN when defined for the build.
// -----------------------------------------------------------------------------
module tb_mux_stream_n;

   localparam int NUM_CH = 4;
   localparam int DATA_W = 8;
   localparam int SEL_W  = 2;

   logic                     clk_in = 1'b0;
   logic                     rst_in;
   logic [NUM_CH*DATA_W-1:0] data_in;
   logic [NUM_CH-1:0]        valid_in;
   logic [NUM_CH-1:0]        last_in;
   logic [NUM_CH-1:0]        ready_out;
   logic                     mode_in;
   logic [SEL_W-1:0]         sel_in;
   logic [DATA_W-1:0]        y_data_out;
   logic                     y_last_out;
   logic [SEL_W-1:0]         y_ch_out;
   logic                     y_valid_out;
   logic                     y_ready_in;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];

   mux_stream_n #(
      .NUM_CH (NUM_CH),
      .DATA_W (DATA_W)
   ) dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .data_in     (data_in),
      .valid_in    (valid_in),
      .last_in     (last_in),
      .ready_out   (ready_out),
      .mode_in     (mode_in),
      .sel_in      (sel_in),
      .y_data_out  (y_data_out),
      .y_last_out  (y_last_out),
      .y_ch_out    (y_ch_out),
      .y_valid_out (y_valid_out),
      .y_ready_in  (y_ready_in)
   );

   // ---------------------------------------------------------------------------
   // Clock / watchdog
   // ---------------------------------------------------------------------------
   always #5 clk_in = ~clk_in;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk_beat(input logic [1:0] ch, input logic [7:0] d, input logic l);
      return {21'b0, l, d, ch};
   endfunction

   // Pops one expected beat and compares the whole output stage against it.
   task automatic check_beat(input string tag);
      logic [31:0] e;
      e = exp_q.pop_front();
      check({tag, "_valid"}, 32'(y_valid_out), 1);
      check({tag, "_ch"},    32'(y_ch_out),    32'(e[1:0]));
      check({tag, "_data"},  32'(y_data_out),  32'(e[9:2]));
      check({tag, "_last"},  32'(y_last_out),  32'(e[10]));
   endtask

   // ---------------------------------------------------------------------------
   // Drivers
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_ch(input int k, input logic [7:0] d, input logic v, input logic l);
      data_in[k*DATA_W +: DATA_W] = d;
      valid_in[k] = v;
      last_in[k]  = l;
   endtask

   task automatic clear_inputs();
      data_in  = '0;
      valid_in = '0;
      last_in  = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_in = 1'b1;
      tick();
      tick();
      rst_in = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int          cnt0;
      int          cnt1;
      logic [3:0]  rdy;

      rst_in     = 1'b1;
      mode_in    = 1'b0;
      sel_in     = '0;
      y_ready_in = 1'b1;
      clear_inputs();
      tick();

      // Reset: nothing accepted even with every channel valid.
      valid_in = '1;
      settle();
      check("rst_ready", 32'(ready_out), 0);
      tick();
      check("rst_valid", 32'(y_valid_out), 0);
      check("rst_data",  32'(y_data_out),  0);
      check("rst_last",  32'(y_last_out),  0);
      check("rst_ch",    32'(y_ch_out),    0);
      rst_in = 1'b0;
      clear_inputs();

      // T1: fixed select of ch2 while ch0 also offers a beat.
      mode_in = 1'b0;
      sel_in  = 2'd2;
      set_ch(0, 8'h11, 1'b1, 1'b1);
      set_ch(2, 8'hA5, 1'b1, 1'b1);
      settle();
      check("t1_ready", 32'(ready_out), 32'h4);
      tick();
      check("t1_valid", 32'(y_valid_out), 1);
      check("t1_data",  32'(y_data_out),  32'hA5);
      check("t1_ch",    32'(y_ch_out),    2);
      check("t1_ready_hold", 32'(ready_out), 32'h4);
      tick();
      check("t1_ch_again", 32'(y_ch_out), 2);
      clear_inputs();
      tick();
      check("t1_drain_valid", 32'(y_valid_out), 0);
      check("t1_drain_data",  32'(y_data_out),  32'hA5);

      // T2: round-robin, all channels valid, full throughput.
      do_reset();
      mode_in = 1'b1;
      for (int k = 0; k < NUM_CH; k++) set_ch(k, 8'(8'h10 + k), 1'b1, 1'b1);
      settle();
      check("t2_ready", 32'(ready_out), 32'h1);
      for (int i = 0; i < 6; i++) exp_q.push_back(mk_beat(2'(i % 4), 8'(8'h10 + (i % 4)), 1'b1));
      for (int i = 0; i < 6; i++) begin
         tick();
         check_beat("t2");
      end

      // T3: round-robin with only ch1 and ch3 valid.
      do_reset();
      mode_in = 1'b1;
      set_ch(1, 8'h31, 1'b1, 1'b1);
      set_ch(3, 8'h33, 1'b1, 1'b1);
      exp_q.push_back(mk_beat(2'd1, 8'h31, 1'b1));
      exp_q.push_back(mk_beat(2'd3, 8'h33, 1'b1));
      exp_q.push_back(mk_beat(2'd1, 8'h31, 1'b1));
      exp_q.push_back(mk_beat(2'd3, 8'h33, 1'b1));
      for (int i = 0; i < 4; i++) begin
         tick();
         check_beat("t3");
      end

      // T4: backpressure on the held ch3 beat, then drain plus refill.
      y_ready_in = 1'b0;
      settle();
      check("t4_ready_stall", 32'(ready_out), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t4_hold_valid", 32'(y_valid_out), 1);
         check("t4_hold_ch",    32'(y_ch_out),    3);
         check("t4_hold_data",  32'(y_data_out),  32'h33);
         check("t4_hold_ready", 32'(ready_out),   0);
      end
      y_ready_in = 1'b1;
      settle();
      check("t4_ready_resume", 32'(ready_out), 32'h2);
      exp_q.push_back(mk_beat(2'd1, 8'h31, 1'b1));
      tick();
      check_beat("t4_refill");

      // T5: ch0 3-beat packet against ch1 2-beat packet, round-robin.
      do_reset();
      mode_in    = 1'b1;
      y_ready_in = 1'b1;
`ifdef MUX_STREAM_LOCK_EN
      exp_q.push_back(mk_beat(2'd0, 8'hA0, 1'b0));
      exp_q.push_back(mk_beat(2'd0, 8'hA1, 1'b0));
      exp_q.push_back(mk_beat(2'd0, 8'hA2, 1'b1));
      exp_q.push_back(mk_beat(2'd1, 8'hB0, 1'b0));
      exp_q.push_back(mk_beat(2'd1, 8'hB1, 1'b1));
`else
      exp_q.push_back(mk_beat(2'd0, 8'hA0, 1'b0));
      exp_q.push_back(mk_beat(2'd1, 8'hB0, 1'b0));
      exp_q.push_back(mk_beat(2'd0, 8'hA1, 1'b0));
      exp_q.push_back(mk_beat(2'd1, 8'hB1, 1'b1));
      exp_q.push_back(mk_beat(2'd0, 8'hA2, 1'b1));
`endif
      cnt0 = 0;
      cnt1 = 0;
      for (int i = 0; i < 5; i++) begin
         set_ch(0, 8'(8'hA0 + cnt0), cnt0 < 3, cnt0 == 2);
         set_ch(1, 8'(8'hB0 + cnt1), cnt1 < 2, cnt1 == 1);
         settle();
         rdy = ready_out;
         tick();
         if (rdy[0]) cnt0++;
         if (rdy[1]) cnt1++;
         check_beat("t5");
      end

      // T6: reset mid-packet (ch1 locked when the feature is built in).
      do_reset();
      mode_in = 1'b1;
      set_ch(1, 8'h61, 1'b1, 1'b0);
      tick();
      check("t6_pre_ch", 32'(y_ch_out), 1);
      rst_in = 1'b1;
      for (int k = 0; k < NUM_CH; k++) set_ch(k, 8'(8'h70 + k), 1'b1, 1'b0);
      settle();
      check("t6_rst_ready", 32'(ready_out), 0);
      tick();
      rst_in = 1'b0;
      check("t6_valid", 32'(y_valid_out), 0);
      check("t6_ch",    32'(y_ch_out),    0);
      settle();
      check("t6_ready", 32'(ready_out), 32'h1);
      exp_q.push_back(mk_beat(2'd0, 8'h70, 1'b0));
      tick();
      check_beat("t6_first");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
